// File: rtl/axis_eth_tx_framer.sv
// Purpose: sends the 6-word MAC TX control packet, then forwards one frame via a 1-beat slice, zero-padding runts.
// Latency: first txd beat valid 1 cycle after its input accept; no txd beat before the last txc handshake.
// Backpressure: txc/txd tready stall the FSM in place; input tready only in DATA, slice runs with no bubbles.
module axis_eth_tx_framer #(
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter bit          PAD_EN          = 1'b1,
  parameter logic [3:0]  TXC_FLAG        = 4'hA
) (
  input  logic        axis_clk,
  input  logic        axis_aresetn,
  input  logic        tx_en,
  input  logic [31:0] s_axis_eth_tdata,
  input  logic [3:0]  s_axis_eth_tkeep,
  input  logic        s_axis_eth_tvalid,
  output logic        s_axis_eth_tready,
  input  logic        s_axis_eth_tlast,
  output logic [31:0] m_axis_txc_tdata,
  output logic [3:0]  m_axis_txc_tkeep,
  output logic        m_axis_txc_tvalid,
  input  logic        m_axis_txc_tready,
  output logic        m_axis_txc_tlast,
  output logic [31:0] m_axis_txd_tdata,
  output logic [3:0]  m_axis_txd_tkeep,
  output logic        m_axis_txd_tvalid,
  input  logic        m_axis_txd_tready,
  output logic        m_axis_txd_tlast,
  output logic        busy,
  output logic        frame_sent,
  output logic [15:0] frame_len_bytes
);

  typedef enum logic [2:0] {S_IDLE, S_CTRL, S_DATA, S_PAD, S_LAST} state_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  localparam logic [15:0] MIN_B = 16'(MIN_FRAME_BYTES);

  state_t      state_q, state_d;
  logic [2:0]  w_q, w_d;
  logic        txc_vld_q, txc_vld_d;
  beat_t       txd_q, txd_d;
  logic        txd_vld_q, txd_vld_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic        sent_q, sent_d;

  logic        txc_hs, txd_hs, slot_free, s_rdy, s_hs;
  logic [2:0]  keep_pop;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_new, cnt_rnd, cnt_pad;
  logic [31:0] keep_mask;
  logic        long_enough, pad_last;

  assign txc_hs    = txc_vld_q && m_axis_txc_tready;
  assign txd_hs    = txd_vld_q && m_axis_txd_tready;
  assign slot_free = !txd_vld_q || m_axis_txd_tready;
  assign s_rdy     = (state_q == S_DATA) && slot_free;
  assign s_hs      = s_rdy && s_axis_eth_tvalid;
  assign cnt_pad   = cnt_q + 16'd4;
  assign pad_last  = (cnt_pad == MIN_B);

  // Byte accounting for the input beat: saturating sum, runt round-up and lane mask.
  always_comb begin
    keep_pop  = 3'd0;
    keep_mask = '0;
    for (int i = 0; i < 4; i++) begin
      keep_pop             = keep_pop + {2'b00, s_axis_eth_tkeep[i]};
      keep_mask[8*i +: 8]  = {8{s_axis_eth_tkeep[i]}};
    end
    cnt_sum     = {1'b0, cnt_q} + {14'b0, keep_pop};
    cnt_new     = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    // Only used for runts, which are far below the saturation point.
    cnt_rnd     = (cnt_new + 16'd3) & ~16'd3;
    long_enough = (cnt_new >= MIN_B) || !PAD_EN;
  end

  // Next-state logic for the frame FSM, slice registers and counters.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    txc_vld_d = txc_vld_q;
    txd_d     = txd_q;
    txd_vld_d = txd_vld_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sent_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_en && s_axis_eth_tvalid) begin
          state_d   = S_CTRL;
          txc_vld_d = 1'b1;
          w_d       = '0;
        end
      end
      S_CTRL: begin
        if (txc_hs) begin
          if (w_q == 3'd5) begin
            txc_vld_d = 1'b0;
            w_d       = '0;
            state_d   = S_DATA;
          end else begin
            w_d = w_q + 3'd1;
          end
        end
      end
      S_DATA: begin
        if (s_hs) begin
          txd_vld_d  = 1'b1;
          txd_d.dat  = s_axis_eth_tdata;
          txd_d.keep = s_axis_eth_tkeep;
          txd_d.last = 1'b0;
          cnt_d      = cnt_new;
          if (s_axis_eth_tlast) begin
            if (long_enough) begin
              txd_d.last = 1'b1;
              state_d    = S_LAST;
            end else begin
              // Runt: the partial beat becomes a full word with zeroed tail bytes.
              txd_d.dat  = s_axis_eth_tdata & keep_mask;
              txd_d.keep = 4'hF;
              cnt_d      = cnt_rnd;
              // Rounding up may already reach the minimum (e.g. 57 bytes), so no pad words follow.
              if (cnt_rnd >= MIN_B) begin
                txd_d.last = 1'b1;
                state_d    = S_LAST;
              end else begin
                state_d = S_PAD;
              end
            end
          end
        end else if (txd_hs) begin
          txd_vld_d = 1'b0;
        end
      end
      S_PAD: begin
        if (slot_free) begin
          txd_vld_d  = 1'b1;
          txd_d.dat  = '0;
          txd_d.keep = 4'hF;
          txd_d.last = pad_last;
          cnt_d      = cnt_pad;
          if (pad_last) state_d = S_LAST;
        end
      end
      S_LAST: begin
        if (txd_hs) begin
          txd_vld_d = 1'b0;
          len_d     = cnt_q;
          sent_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      txc_vld_q <= 1'b0;
      txd_q     <= '0;
      txd_vld_q <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      txc_vld_q <= txc_vld_d;
      txd_q     <= txd_d;
      txd_vld_q <= txd_vld_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sent_q    <= sent_d;
    end
  end

  assign s_axis_eth_tready = s_rdy;
  assign m_axis_txc_tvalid = txc_vld_q;
  assign m_axis_txc_tkeep  = {4{txc_vld_q}};
  assign m_axis_txc_tdata  = (txc_vld_q && (w_q == 3'd0)) ? {TXC_FLAG, 28'h0} : 32'h0;
  assign m_axis_txc_tlast  = txc_vld_q && (w_q == 3'd5);
  assign m_axis_txd_tvalid = txd_vld_q;
  assign m_axis_txd_tdata  = txd_q.dat;
  assign m_axis_txd_tkeep  = txd_q.keep;
  assign m_axis_txd_tlast  = txd_q.last;
  assign busy              = (state_q != S_IDLE);
  assign frame_sent        = sent_q;
  assign frame_len_bytes   = len_q;

endmodule

// File: tb/tb_axis_eth_tx_framer.sv
// Bench for axis_eth_tx_framer: padding and non-padding instances, scoreboard fed by a byte-level frame model.
// Stimulus issues frames with random gaps and random MAC readiness; a negedge monitor pops and compares.
// Covers reset values, control packet, runt padding, tx_en gating, stall stability and mid-frame reset.
module tb_axis_eth_tx_framer;
  localparam int MIN = 60;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n, tx_en, b_tx_en, rand_rdy;

  logic [31:0] a_s_dat, a_txc_dat, a_txd_dat;
  logic [3:0]  a_s_keep, a_txc_keep, a_txd_keep;
  logic        a_s_vld, a_s_rdy, a_s_last, a_txc_vld, a_txc_rdy, a_txc_last;
  logic        a_txd_vld, a_txd_rdy, a_txd_last, a_busy, a_sent;
  logic [15:0] a_len;

  logic [31:0] b_s_dat, b_txc_dat, b_txd_dat;
  logic [3:0]  b_s_keep, b_txc_keep, b_txd_keep;
  logic        b_s_vld, b_s_rdy, b_s_last, b_txc_vld, b_txc_rdy, b_txc_last;
  logic        b_txd_vld, b_txd_rdy, b_txd_last, b_busy, b_sent;
  logic [15:0] b_len;

  int checks = 0;
  int failures = 0;

  beat_t       exp_txd[$], exp_txd_b[$];
  logic [32:0] exp_txc[$];
  int          exp_len[$], exp_len_b[$];
  logic [7:0]  fb[$];

  always #5 clk = ~clk;

  axis_eth_tx_framer #(.MIN_FRAME_BYTES(MIN), .PAD_EN(1'b1), .TXC_FLAG(4'hA)) dut (
    .axis_clk(clk), .axis_aresetn(rst_n), .tx_en(tx_en),
    .s_axis_eth_tdata(a_s_dat), .s_axis_eth_tkeep(a_s_keep), .s_axis_eth_tvalid(a_s_vld),
    .s_axis_eth_tready(a_s_rdy), .s_axis_eth_tlast(a_s_last),
    .m_axis_txc_tdata(a_txc_dat), .m_axis_txc_tkeep(a_txc_keep), .m_axis_txc_tvalid(a_txc_vld),
    .m_axis_txc_tready(a_txc_rdy), .m_axis_txc_tlast(a_txc_last),
    .m_axis_txd_tdata(a_txd_dat), .m_axis_txd_tkeep(a_txd_keep), .m_axis_txd_tvalid(a_txd_vld),
    .m_axis_txd_tready(a_txd_rdy), .m_axis_txd_tlast(a_txd_last),
    .busy(a_busy), .frame_sent(a_sent), .frame_len_bytes(a_len)
  );

  axis_eth_tx_framer #(.MIN_FRAME_BYTES(MIN), .PAD_EN(1'b0), .TXC_FLAG(4'hA)) dut_nopad (
    .axis_clk(clk), .axis_aresetn(rst_n), .tx_en(b_tx_en),
    .s_axis_eth_tdata(b_s_dat), .s_axis_eth_tkeep(b_s_keep), .s_axis_eth_tvalid(b_s_vld),
    .s_axis_eth_tready(b_s_rdy), .s_axis_eth_tlast(b_s_last),
    .m_axis_txc_tdata(b_txc_dat), .m_axis_txc_tkeep(b_txc_keep), .m_axis_txc_tvalid(b_txc_vld),
    .m_axis_txc_tready(b_txc_rdy), .m_axis_txc_tlast(b_txc_last),
    .m_axis_txd_tdata(b_txd_dat), .m_axis_txd_tkeep(b_txd_keep), .m_axis_txd_tvalid(b_txd_vld),
    .m_axis_txd_tready(b_txd_rdy), .m_axis_txd_tlast(b_txd_last),
    .busy(b_busy), .frame_sent(b_sent), .frame_len_bytes(b_len)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT produced an output with an empty scoreboard at %0t", name, $time);
  endtask

  task automatic timeout_stop(input string name);
    checks++;
    failures++;
    $display("FAIL %s: input not accepted within 3000 cycles", name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stopped on stalled input");
  endtask

  function automatic logic [31:0] mask32(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{k[l]}};
    return m;
  endfunction

  // Frame model: bytes go out in order, 4 per word; a padded runt becomes MIN bytes with zero fill.
  function automatic void model(input bit pad_en);
    int    out_len;
    beat_t e;
    out_len = (pad_en && fb.size() < MIN) ? MIN : fb.size();
    for (int b = 0; b * 4 < out_len; b++) begin
      e = '0;
      for (int l = 0; l < 4; l++) begin
        if (b * 4 + l < out_len) begin
          e.keep[l]     = 1'b1;
          e.dat[8*l +: 8] = (b * 4 + l < fb.size()) ? fb[b*4+l] : 8'h00;
        end
      end
      e.last = ((b + 1) * 4 >= out_len);
      if (pad_en) exp_txd.push_back(e);
      else        exp_txd_b.push_back(e);
    end
    if (pad_en) exp_len.push_back(out_len);
    else        exp_len_b.push_back(out_len);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_txc"}, 64'({a_txc_dat, a_txc_keep, a_txc_vld, a_txc_last}), 64'(0));
    chk({tag, "_txd"}, 64'({a_txd_dat, a_txd_keep, a_txd_vld, a_txd_last}), 64'(0));
    chk({tag, "_status"}, 64'({a_busy, a_sent, a_len, a_s_rdy}), 64'(0));
  endtask

  // Frame onto the padding instance; optional tx_en hold-off, tx_en drop and reset after a chosen beat.
  task automatic send_a(input int len, input int hold_off, input bit drop_en, input int gap_pct,
                        input int rst_beat);
    int nb, t;
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    model(1'b1);
    for (int w = 0; w < 6; w++) exp_txc.push_back({(w == 5), (w == 0) ? 32'hA000_0000 : 32'h0});
    nb = (len + 3) / 4;
    if (hold_off > 0) tx_en = 1'b0;
    for (int b = 0; b < nb; b++) begin
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        a_s_vld = 1'b0;
        @(posedge clk); #1;
      end
      a_s_dat  = $urandom;
      a_s_keep = '0;
      for (int l = 0; l < 4; l++) begin
        if (b * 4 + l < len) begin
          a_s_keep[l]       = 1'b1;
          a_s_dat[8*l +: 8] = fb[b*4+l];
        end
      end
      a_s_last = (b == nb - 1);
      a_s_vld  = 1'b1;
      if (b == 0 && hold_off > 0) begin
        repeat (hold_off) begin
          @(negedge clk);
          chk("gated_busy", 64'(a_busy), 64'(0));
          chk("gated_tready", 64'(a_s_rdy), 64'(0));
        end
        tx_en = 1'b1;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!a_s_rdy && t < 3000);
      if (!a_s_rdy) timeout_stop("input_accept");
      @(posedge clk); #1;
      if (drop_en && b == 1) tx_en = 1'b0;
      if (b == rst_beat) begin
        rst_n    = 1'b0;
        a_s_vld  = 1'b0;
        a_s_last = 1'b0;
        #1;
        check_idle("midframe_reset");
        exp_txd.delete();
        exp_txc.delete();
        exp_len.delete();
        return;
      end
    end
    a_s_vld  = 1'b0;
    a_s_last = 1'b0;
    tx_en    = 1'b1;
  endtask

  // Frame onto the non-padding instance with the MAC always ready.
  task automatic send_b(input int len);
    int nb, t;
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    model(1'b0);
    nb = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      b_s_dat  = $urandom;
      b_s_keep = '0;
      for (int l = 0; l < 4; l++) begin
        if (b * 4 + l < len) begin
          b_s_keep[l]       = 1'b1;
          b_s_dat[8*l +: 8] = fb[b*4+l];
        end
      end
      b_s_last = (b == nb - 1);
      b_s_vld  = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!b_s_rdy && t < 3000);
      if (!b_s_rdy) timeout_stop("nopad_input_accept");
      @(posedge clk); #1;
    end
    b_s_vld  = 1'b0;
    b_s_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_txd.size() + exp_txc.size() + exp_len.size() +
            exp_txd_b.size() + exp_len_b.size()) > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_outstanding", 64'(exp_txd.size() + exp_txc.size() + exp_len.size() +
                                 exp_txd_b.size() + exp_len_b.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // MAC readiness: random while rand_rdy is set, otherwise always ready.
  initial begin
    a_txc_rdy = 1'b1;
    a_txd_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      a_txc_rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      a_txd_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  logic [32:0] txc_prev, ec;
  beat_t       txd_prev, eb;
  logic        txc_stall, txd_stall, txd_mid;
  int          txc_frames, txd_frames, el;

  // Monitor for the padding instance: scoreboard pops, stall stability and control-before-data order.
  always @(negedge clk) begin
    if (!rst_n) begin
      txc_stall  = 1'b0;
      txd_stall  = 1'b0;
      txd_mid    = 1'b0;
      txc_frames = 0;
      txd_frames = 0;
    end else begin
      if (txc_stall)
        chk("txc_stall_hold", 64'({a_txc_vld, a_txc_last, a_txc_dat}), 64'({1'b1, txc_prev}));
      if (a_txc_vld && a_txc_rdy) begin
        if (exp_txc.size() == 0) unexpected("txc_word");
        else begin
          ec = exp_txc.pop_front();
          chk("txc_word", 64'({a_txc_last, a_txc_dat}), 64'(ec));
          chk("txc_keep", 64'(a_txc_keep), 64'(4'hF));
        end
        if (a_txc_last) txc_frames++;
      end
      txc_stall = a_txc_vld && !a_txc_rdy;
      txc_prev  = {a_txc_last, a_txc_dat};

      if (txd_stall)
        chk("txd_stall_hold", 64'({a_txd_vld, a_txd_dat, a_txd_keep, a_txd_last}), 64'({1'b1, txd_prev}));
      if (a_txd_vld && a_txd_rdy) begin
        if (!txd_mid) chk("txc_before_txd", 64'(txc_frames > txd_frames), 64'(1));
        if (exp_txd.size() == 0) unexpected("txd_beat");
        else begin
          eb = exp_txd.pop_front();
          chk("txd_data", 64'(a_txd_dat & mask32(eb.keep)), 64'(eb.dat));
          chk("txd_keep_last", 64'({a_txd_keep, a_txd_last}), 64'({eb.keep, eb.last}));
        end
        txd_mid = !a_txd_last;
        if (a_txd_last) txd_frames++;
      end
      txd_stall = a_txd_vld && !a_txd_rdy;
      txd_prev  = {a_txd_dat, a_txd_keep, a_txd_last};

      if (a_sent) begin
        if (exp_len.size() == 0) unexpected("frame_sent");
        else begin
          el = exp_len.pop_front();
          chk("frame_len", 64'(a_len), 64'(el));
        end
      end
    end
  end

  beat_t eb2;
  int    el2;

  // Monitor for the non-padding instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_txd_vld && b_txd_rdy) begin
        if (exp_txd_b.size() == 0) unexpected("nopad_txd_beat");
        else begin
          eb2 = exp_txd_b.pop_front();
          chk("nopad_txd_data", 64'(b_txd_dat & mask32(eb2.keep)), 64'(eb2.dat));
          chk("nopad_txd_keep_last", 64'({b_txd_keep, b_txd_last}), 64'({eb2.keep, eb2.last}));
        end
      end
      if (b_sent) begin
        if (exp_len_b.size() == 0) unexpected("nopad_frame_sent");
        else begin
          el2 = exp_len_b.pop_front();
          chk("nopad_frame_len", 64'(b_len), 64'(el2));
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    tx_en    = 1'b1;
    b_tx_en  = 1'b1;
    rand_rdy = 1'b0;
    a_s_dat  = '0; a_s_keep = '0; a_s_vld = 1'b0; a_s_last = 1'b0;
    b_s_dat  = '0; b_s_keep = '0; b_s_vld = 1'b0; b_s_last = 1'b0;
    b_txc_rdy = 1'b1;
    b_txd_rdy = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_idle("in_reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("after_reset");
    @(posedge clk); #1;

    send_a(64, 0, 1'b0, 0, -1);   // full-size frame, no padding
    drain();
    send_a(42, 0, 1'b0, 0, -1);   // ARP-size runt: masked tail plus 4 zero words
    drain();
    send_a(32, 6, 1'b1, 0, -1);   // tx_en gating in IDLE, then dropped mid-frame
    drain();
    send_a(1, 0, 1'b0, 0, -1);    // single-beat frame
    drain();
    send_a(57, 0, 1'b0, 0, -1);   // rounds up exactly to the minimum
    drain();
    send_b(20);
    send_b(42);
    drain();

    rand_rdy = 1'b1;
    for (int f = 0; f < 100; f++)
      send_a(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(61, 300)),
             0, 1'b0, 30, -1);
    drain();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;

    send_a(64, 0, 1'b0, 0, 5);    // reset while beat 5 sits in the slice
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(64, 0, 1'b0, 0, -1);
    send_a(17, 0, 1'b0, 0, -1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
